// File: rtl/fp_add_normalize_round.sv
// fp_add_normalize_round: add/subtract, normalize, round-to-nearest-even and
// pack stage of the binary32 adder, fed by the exponent-alignment stage.
// Three registered stages share one advance enable driven by the output side.
module fp_add_normalize_round #(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 23
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            signA,
  input  logic                            signB,
  input  logic [MANT_WIDTH:0]             alignedMantissaA,
  input  logic [MANT_WIDTH:0]             alignedMantissaB,
  input  logic                            guardBit,
  input  logic                            roundBit,
  input  logic                            stickyBit,
  input  logic [EXP_WIDTH-1:0]            exponentOut,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   result,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            zero
);

  // significand incl. implicit one, extended with G/R/S, plus a carry bit
  localparam int unsigned SIG_W  = MANT_WIDTH + 1;
  localparam int unsigned EXT_W  = SIG_W + 3;
  localparam int unsigned SUM_W  = EXT_W + 1;
  // internal exponent has headroom for +1 (carry) and +1 (rounding carry)
  localparam int unsigned EXPI_W = EXP_WIDTH + 2;
  localparam int unsigned LZC_W  = $clog2(EXT_W + 1);
  localparam logic [EXPI_W-1:0] EXP_MAX = EXPI_W'((1 << EXP_WIDTH) - 1);

  // leading-zero count of the extended significand; EXT_W when all zero
  function automatic logic [LZC_W-1:0] countLeadingZeros(input logic [EXT_W-1:0] v);
    logic [LZC_W-1:0] n;
    n = LZC_W'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (v[i]) n = LZC_W'(int'(EXT_W) - 1 - i);
    end
    return n;
  endfunction

  logic adv;

  // stage 1 registers
  logic                 s1Valid;
  logic [SUM_W-1:0]     s1Sum;
  logic                 s1Sign;
  logic [EXP_WIDTH-1:0] s1Exp;

  // stage 2 registers (implicit one dropped: it is 1 for every non-zero value)
  logic                 s2Valid;
  logic [EXT_W-2:0]     s2Bits;
  logic [EXPI_W-1:0]    s2Exp;
  logic                 s2Sign;
  logic                 s2Zero;
  logic                 s2Underflow;

  // stage 1 combinational
  logic                 aIsLarger;
  logic [EXT_W-1:0]     largeExt;
  logic [EXT_W-1:0]     smallExt;
  logic [SUM_W-1:0]     s1SumC;
  logic                 s1SignC;

  // stage 2 combinational
  logic [LZC_W-1:0]     lzcC;
  logic [EXT_W-1:0]     normC;
  logic [EXPI_W-1:0]    s2ExpC;
  logic                 tooSmallC;
  logic                 nonZeroC;
  logic                 s2ZeroC;
  logic                 s2UnderflowC;

  // stage 3 combinational
  logic [MANT_WIDTH-1:0] fracC;
  logic                  roundUpC;
  logic [SIG_W-1:0]      fracIncC;
  logic [EXPI_W-1:0]     finalExpC;
  logic [EXP_WIDTH+MANT_WIDTH:0] resultC;
  logic                  overflowC;
  logic                  underflowC;
  logic                  zeroC;

  // whole pipeline moves when the output register is empty or being drained
  assign adv     = !outValid || outReady;
  assign inReady = adv;

  // stage 1: pick the larger magnitude and add or subtract extended operands
  always_comb begin
    aIsLarger = 1'b0;
    largeExt  = '0;
    smallExt  = '0;
    s1SumC    = '0;
    s1SignC   = 1'b0;
    aIsLarger = alignedMantissaA >= alignedMantissaB;
    if (aIsLarger) begin
      largeExt = {alignedMantissaA, 3'b000};
      smallExt = {alignedMantissaB, guardBit, roundBit, stickyBit};
    end else begin
      largeExt = {alignedMantissaB, 3'b000};
      smallExt = {alignedMantissaA, guardBit, roundBit, stickyBit};
    end
    if (signA == signB) begin
      s1SumC  = SUM_W'(largeExt) + SUM_W'(smallExt);
      s1SignC = signA;
    end else begin
      s1SumC  = SUM_W'(largeExt) - SUM_W'(smallExt);
      s1SignC = aIsLarger ? signA : signB;
    end
  end

  // stage 1 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Sum   <= '0;
      s1Sign  <= 1'b0;
      s1Exp   <= '0;
    end else if (adv) begin
      s1Valid <= inValid;
      s1Sum   <= s1SumC;
      s1Sign  <= s1SignC;
      s1Exp   <= exponentOut;
    end
  end

  // stage 2: normalize on carry-out or by leading-zero count, detect flush to zero
  always_comb begin
    lzcC      = '0;
    normC     = '0;
    s2ExpC    = '0;
    tooSmallC = 1'b0;
    lzcC      = countLeadingZeros(s1Sum[EXT_W-1:0]);
    if (s1Sum[SUM_W-1]) begin
      // bit shifted out on the right folds into sticky
      normC     = {s1Sum[SUM_W-1:2], s1Sum[1] | s1Sum[0]};
      s2ExpC    = EXPI_W'(s1Exp) + EXPI_W'(1);
      tooSmallC = 1'b0;
    end else begin
      normC     = s1Sum[EXT_W-1:0] << lzcC;
      s2ExpC    = EXPI_W'(s1Exp) - EXPI_W'(lzcC);
      tooSmallC = EXPI_W'(s1Exp) <= EXPI_W'(lzcC);
    end
    // after normalization the top bit is set for every non-zero value
    nonZeroC     = normC[EXT_W-1];
    s2ZeroC      = !nonZeroC || tooSmallC;
    s2UnderflowC = nonZeroC && tooSmallC;
  end

  // stage 2 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2Valid     <= 1'b0;
      s2Bits      <= '0;
      s2Exp       <= '0;
      s2Sign      <= 1'b0;
      s2Zero      <= 1'b0;
      s2Underflow <= 1'b0;
    end else if (adv) begin
      s2Valid     <= s1Valid;
      s2Bits      <= normC[EXT_W-2:0];
      s2Exp       <= s2ExpC;
      s2Sign      <= s1Sign;
      s2Zero      <= s2ZeroC;
      s2Underflow <= s2UnderflowC;
    end
  end

  // stage 3: round to nearest even, saturate to infinity, pack binary32
  always_comb begin
    fracC       = '0;
    roundUpC    = 1'b0;
    fracIncC    = '0;
    finalExpC   = '0;
    resultC     = '0;
    overflowC   = 1'b0;
    underflowC  = 1'b0;
    zeroC       = 1'b0;
    fracC       = s2Bits[EXT_W-2:3];
    roundUpC    = s2Bits[2] & (s2Bits[1] | s2Bits[0] | fracC[0]);
    // a carry out of the fraction means the significand became 2.0:
    // fraction wraps to zero and the exponent steps up
    fracIncC    = SIG_W'(fracC) + SIG_W'(roundUpC);
    finalExpC   = s2Exp + EXPI_W'(fracIncC[MANT_WIDTH]);
    if (s2Zero) begin
      zeroC      = 1'b1;
      underflowC = s2Underflow;
    end else if (finalExpC >= EXP_MAX) begin
      resultC   = {s2Sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      overflowC = 1'b1;
    end else begin
      resultC = {s2Sign, finalExpC[EXP_WIDTH-1:0], fracIncC[MANT_WIDTH-1:0]};
    end
  end

  // stage 3 register: result and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid  <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      outValid  <= s2Valid;
      result    <= resultC;
      overflow  <= overflowC;
      underflow <= underflowC;
      zero      <= zeroC;
    end
  end

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Bench for fp_add_normalize_round: exact-arithmetic reference model,
// scoreboard queue checked on every output transfer, directed literal vectors.
module tb_fp_add_normalize_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic        signA, signB;
  logic [23:0] alignedMantissaA, alignedMantissaB;
  logic        guardBit, roundBit, stickyBit;
  logic [7:0]  exponentOut;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        overflow, underflow, zero;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [34:0] expQ[$];

  fp_add_normalize_round dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .signA(signA), .signB(signB),
    .alignedMantissaA(alignedMantissaA), .alignedMantissaB(alignedMantissaB),
    .guardBit(guardBit), .roundBit(roundBit), .stickyBit(stickyBit),
    .exponentOut(exponentOut), .outValid(outValid), .outReady(outReady),
    .result(result), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // exact value of the operands as integers, rounded to 24 significant bits;
  // returns {zero, underflow, overflow, result}
  function automatic logic [34:0] model(input logic sA, input logic sB,
                                        input logic [23:0] mA, input logic [23:0] mB,
                                        input logic g, input logic r, input logic s,
                                        input logic [7:0] e);
    longint bigV, smlV, m, q, rem, half, ex;
    int p, sh;
    logic sg;
    if (mA >= mB) begin
      bigV = longint'(mA) * 8;
      smlV = longint'(mB) * 8 + longint'({g, r, s});
      sg   = sA;
    end else begin
      bigV = longint'(mB) * 8;
      smlV = longint'(mA) * 8 + longint'({g, r, s});
      sg   = sB;
    end
    if (sA == sB) begin
      m  = bigV + smlV;
      sg = sA;
    end else begin
      m = bigV - smlV;
    end
    if (m == 0) return {3'b100, 32'h0};
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    ex = longint'(e) + longint'(p) - 26;
    if (ex <= 0) return {3'b110, 32'h0};
    if (p > 23) begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end else begin
      q = m << (23 - p);
    end
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      ex++;
    end
    if (ex >= 255) return {3'b001, sg, 8'hFF, 23'h0};
    return {3'b000, sg, ex[7:0], q[22:0]};
  endfunction

  // scoreboard: record accepted inputs, compare every output transfer
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
    end else begin
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("FAIL spuriousOut: got result %h with no pending input", result);
        end else begin
          check("stream", 64'({zero, underflow, overflow, result}), 64'(expQ.pop_front()));
        end
      end
      if (inValid && inReady)
        expQ.push_back(model(signA, signB, alignedMantissaA, alignedMantissaB,
                             guardBit, roundBit, stickyBit, exponentOut));
    end
  end

  // legal aligned operand set: larger has implicit one, smaller shifted right
  task automatic randStim();
    logic [23:0] big, sml, al;
    logic [49:0] w;
    int d, kind;
    kind = $urandom_range(0, 3);
    big  = 24'h800000 | 24'($urandom);
    sml  = 24'h800000 | 24'($urandom);
    d    = $urandom_range(0, 26);
    if (kind == 0) begin
      sml = big ^ 24'($urandom_range(0, 15));
      d   = 0;
    end
    if (kind == 1) d = $urandom_range(0, 2);
    w  = {sml, 26'b0} >> d;
    al = w[49:26];
    if ($urandom_range(0, 1) == 1) begin
      alignedMantissaA = big;
      alignedMantissaB = al;
    end else begin
      alignedMantissaA = al;
      alignedMantissaB = big;
    end
    guardBit  = w[25];
    roundBit  = w[24];
    stickyBit = |w[23:0];
    signA     = 1'($urandom);
    signB     = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       exponentOut = 8'd254;
      1:       exponentOut = 8'($urandom_range(1, 3));
      default: exponentOut = 8'($urandom_range(1, 254));
    endcase
  endtask

  // one operand set into an empty pipeline; checks 3-cycle latency and value
  task automatic directed(input string name, input logic sA, input logic sB,
                          input logic [23:0] mA, input logic [23:0] mB,
                          input logic g, input logic r, input logic s,
                          input logic [7:0] e, input logic [34:0] want);
    check({name, "/model"}, 64'(model(sA, sB, mA, mB, g, r, s, e)), 64'(want));
    signA = sA; signB = sB;
    alignedMantissaA = mA; alignedMantissaB = mB;
    guardBit = g; roundBit = r; stickyBit = s;
    exponentOut = e;
    inValid = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    check({name, "/inReady"}, 64'(inReady), 64'(1));
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check({name, "/latency"}, 64'(outValid), 64'(c == 3));
    end
    check({name, "/out"}, 64'({zero, underflow, overflow, result}), 64'(want));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(expQ.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  int accepted;

  initial begin
    reset = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    signA = 1'b0; signB = 1'b0;
    alignedMantissaA = '0; alignedMantissaB = '0;
    guardBit = 1'b0; roundBit = 1'b0; stickyBit = 1'b0;
    exponentOut = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rstOutValid", 64'(outValid), 64'(0));
    check("rstResult", 64'({zero, underflow, overflow, result}), 64'(0));
    reset = 1'b0;
    #1;
    check("rstInReady", 64'(inReady), 64'(1));
    @(posedge clk); #1;

    directed("onePlusOne",  1'b0, 1'b0, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 8'd127, {3'b000, 32'h40000000});
    directed("oneHalfMinusOne", 1'b0, 1'b1, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, 8'd127, {3'b000, 32'h3F000000});
    directed("cancel",      1'b0, 1'b1, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 8'd127, {3'b100, 32'h00000000});
    directed("tieEven",     1'b0, 1'b0, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'd127, {3'b000, 32'h3F800000});
    directed("tieOdd",      1'b0, 1'b0, 24'h800001, 24'h000000, 1'b1, 1'b0, 1'b0, 8'd127, {3'b000, 32'h3F800002});
    directed("overflow",    1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 8'd254, {3'b001, 32'h7F800000});
    directed("underflow",   1'b0, 1'b1, 24'h800001, 24'h800000, 1'b0, 1'b0, 1'b0, 8'd1,   {3'b110, 32'h00000000});
    directed("negSum",      1'b1, 1'b1, 24'h800000, 24'h400000, 1'b0, 1'b0, 1'b0, 8'd127, {3'b000, 32'hBFC00000});

    // random traffic with random stalls on both sides
    for (int i = 0; i < 3000; i++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      randStim();
      @(posedge clk); #1;
    end
    drain("drainRandom");

    // backpressure: three sets fill the pipe, then inReady must drop
    outReady = 1'b0;
    inValid  = 1'b1;
    randStim();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bpInReady", 64'(inReady), 64'(c < 3));
      @(posedge clk); #1;
      if (c < 3) randStim();
    end
    outReady = 1'b1;
    accepted = 0;
    for (int c = 0; c < 10 && accepted < 2; c++) begin
      @(negedge clk);
      if (inReady) accepted++;
      @(posedge clk); #1;
      randStim();
    end
    check("bpAccepted", 64'(accepted), 64'(2));
    drain("drainBackpressure");

    // reset with two sets in flight: nothing may emerge afterwards
    outReady = 1'b0;
    inValid  = 1'b1;
    randStim();
    @(posedge clk); #1;
    randStim();
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    check("preRstOutValid", 64'(outValid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("midRstOutValid", 64'(outValid), 64'(0));
    check("midRstResult", 64'({zero, underflow, overflow, result}), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    reset    = 1'b0;
    outReady = 1'b1;
    #1;
    check("postRstInReady", 64'(inReady), 64'(1));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("postRstNoGhost", 64'(outValid), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fp_add_normalize_round.md
Name: fp_add_normalize_round

Overview:
- Pipeline stage directly downstream of the exponent-alignment stage in the single-precision adder.
- Consumes the two aligned 24-bit mantissas (implicit one at bit 23), the shared exponent, and the guard/round/sticky bits of the shifted operand.
- Performs the signed add or subtract, normalizes, rounds to nearest-even and packs an IEEE-754 binary32 result.
- Three-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- EXP_WIDTH, 8, exponent width; only the default is supported and verified.
- MANT_WIDTH, 23, stored fraction width; aligned mantissa width is MANT_WIDTH+1; only the default is supported and verified.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- inValid  input  1  upstream operand set valid
- inReady  output  1  block can accept an operand set this cycle
- signA  input  1  sign of operand A
- signB  input  1  sign of operand B
- alignedMantissaA  input  24  aligned mantissa A, implicit one included
- alignedMantissaB  input  24  aligned mantissa B, implicit one included
- guardBit  input  1  first bit shifted out of the smaller-exponent operand
- roundBit  input  1  second bit shifted out of the smaller-exponent operand
- stickyBit  input  1  OR of all further shifted-out bits
- exponentOut  input  8  common (larger) exponent
- outValid  output  1  result valid
- outReady  input  1  downstream accepts the result
- result  output  32  packed binary32 sum
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero
- zero  output  1  result is +0

Behaviour:
- Reset (asynchronous, any time): all stage valid flags clear; outValid=0, result=0, overflow=0, underflow=0, zero=0. In-flight operands are discarded. inReady=1 once reset deasserts.
- Handshake:
  - Transfer in when inValid && inReady; transfer out when outValid && outReady.
  - Global advance enable adv = !outValid || outReady; inReady = adv.
  - When adv=0 every stage holds its contents. No bubbles are inserted and no data is lost or duplicated.
- Latency: 3 cycles from input accept to outValid under no backpressure. Throughput: 1 result per cycle.
- Larger-operand identification:
  - The operand with the larger alignedMantissa is the larger magnitude; G/R/S belong to the other operand.
  - If the mantissas are equal, G/R/S are necessarily 0.
  - Extended operands are 27 bits: larger = {mant,3'b0}, smaller = {mant,G,R,S}.
- S1, add/sub:
  - signA==signB: 28-bit sum of the extended operands; sign=signA.
  - signA!=signB: larger minus smaller; sign = sign of the larger operand.
  - Equal magnitudes: difference is 0; flag zero.
- S2, normalize:
  - Sum carry out (bit 27): shift right 1, S |= shifted-out bit, exponent+1.
  - Otherwise count leading zeros k of the 27-bit value and shift left k, zero fill; exponent-k.
  - If exponent <= k, or the value is 0: force +0 (zero=1). Also set underflow=1 when the value was non-zero. Denormals are not produced.
- S3, round and pack:
  - Round-to-nearest-even on the 24-bit mantissa: increment if G && (R || S || lsb).
  - If the increment carries out, mantissa becomes 0x800000 and exponent+1.
  - If the final exponent >= 255: result = {sign,8'hFF,23'h0}, overflow=1.
  - Otherwise result = {sign, exponent, mantissa[22:0]}.
  - Zero results are always +0 (0x00000000).
- Flags are registered alongside result and are valid only when outValid=1.
- exponentOut=0 inputs are not defined; upstream never issues them.

Test Plan:
- 1.0+1.0: signs 0, mA=mB=0x800000, exp=127, GRS=0 -> result=0x40000000 on 3rd cycle after accept, flags 0.
- 1.5-1.0: signA=0, mA=0xC00000, signB=1, mB=0x800000, exp=127 -> result=0x3F000000.
- Cancellation: signA=0, signB=1, mA=mB=0x800000, exp=127 -> result=0x00000000, zero=1, underflow=0.
- Rounding tie: mA=0x800000, mB=0x000000, G=1, R=S=0, exp=127 -> 0x3F800000 (no round-up). Same with mA=0x800001 -> 0x3F800002.
- Overflow: exp=254, mA=mB=0xFFFFFF, same signs -> result=0x7F800000, overflow=1.
- Backpressure/reset:
  - Stream 5 sets with outReady=0 -> inReady drops after 3 accepted; all results emerge in order once outReady=1.
  - Assert reset with 2 sets in flight -> outValid=0 immediately; those 2 results are never emitted.
